// File: rtl/expr_pkg.sv
// Shared constants for the expression character stream: ASCII codes,
// operator codes and one-hot transmitter state encodings. The receiver's
// character classifier imports the same package.
package expr_pkg;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  localparam int unsigned ST_W = 4;
  localparam logic [ST_W-1:0] ST_IDLE  = 4'b0001;
  localparam logic [ST_W-1:0] ST_DIGIT = 4'b0010;
  localparam logic [ST_W-1:0] ST_OP    = 4'b0100;
  localparam logic [ST_W-1:0] ST_FIN   = 4'b1000;

endpackage

// File: rtl/expr_char_enc.sv
// Character encoder: maps a BCD digit or an operator code to ASCII.
module expr_char_enc
  import expr_pkg::*;
(
  input  logic       is_op_i,
  input  logic [3:0] digit_i,
  input  logic       op_i,
  output logic [7:0] char_o
);

  // Operators map to '+'/'*', digits to '0'..'9'.
  always_comb begin
    if (is_op_i) char_o = (op_i == OP_MUL) ? CH_STAR : CH_PLUS;
    else         char_o = CH_ZERO + 8'(digit_i);
  end

endmodule

// File: rtl/expr_tx.sv
// Expression transmitter: serializes a latched expression `digit (op digit)*`
// as ASCII over a valid/ready channel.
// Optional evaluator enabled with macro EXPR_TX_EVAL_EN.
module expr_tx
  import expr_pkg::*;
#(
  parameter int unsigned MAX_TERMS = 8,
  parameter int unsigned RES_W     = 16
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [3:0]             nterms,
  input  logic [4*MAX_TERMS-1:0] operands,
  input  logic [MAX_TERMS-2:0]   ops,
  output logic [7:0]             out_char,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [RES_W-1:0]       result
);

  localparam logic [3:0] MAX_N = 4'(MAX_TERMS);

  logic [ST_W-1:0]  state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       nterms_q, nterms_d;
  logic [15:0][3:0] opnd_q, opnd_d;
  logic [15:0]      ops_q, ops_d;
  logic [7:0]       out_char_q, out_char_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic       reject_c, accept_c, xfer_c, last_c;
  logic [7:0] enc_char_c;

  // Request validation against the live inputs.
  always_comb begin
    reject_c = (nterms == 4'd0) || (nterms > MAX_N);
    for (int i = 0; i < int'(MAX_TERMS); i++) begin
      if ((4'(i) < nterms) && (operands[4*i +: 4] > 4'd9)) reject_c = 1'b1;
    end
  end

  assign accept_c = (state_q == ST_IDLE) && start && !reject_c;
  assign xfer_c   = out_valid_q && out_ready;
  assign last_c   = (idx_q == (nterms_q - 4'd1));

  // Next-state, latch and registered-output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    nterms_d = nterms_q;
    opnd_d   = opnd_q;
    ops_d    = ops_q;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (reject_c) begin
            err_d = 1'b1;
          end else begin
            nterms_d = nterms;
            opnd_d   = 64'(operands);
            ops_d    = 16'(ops);
            idx_d    = 4'd0;
            state_d  = ST_DIGIT;
          end
        end
      end
      ST_DIGIT: if (xfer_c) state_d = last_c ? ST_FIN : ST_OP;
      ST_OP: begin
        if (xfer_c) begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_DIGIT;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = (state_d == ST_DIGIT) || (state_d == ST_OP);
    busy_d      = out_valid_d;
    done_d      = (state_d == ST_FIN);
    out_char_d  = out_valid_d ? enc_char_c : 8'h00;
  end

  expr_char_enc u_enc (
    .is_op_i (state_d == ST_OP),
    .digit_i (opnd_d[idx_d]),
    .op_i    (ops_d[idx_d]),
    .char_o  (enc_char_c)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      nterms_q    <= '0;
      opnd_q      <= '0;
      ops_q       <= '0;
      out_char_q  <= 8'h00;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      nterms_q    <= nterms_d;
      opnd_q      <= opnd_d;
      ops_q       <= ops_d;
      out_char_q  <= out_char_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign out_char  = out_char_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

`ifdef EXPR_TX_EVAL_EN
  logic [RES_W-1:0] sum_q, sum_d, prod_q, prod_d, res_q, res_d;
  logic             mul_q, mul_d;

  // Evaluator: prod collects the current product term, sum the finished terms.
  always_comb begin
    sum_d  = sum_q;
    prod_d = prod_q;
    res_d  = res_q;
    mul_d  = mul_q;
    if (accept_c) begin
      sum_d  = '0;
      prod_d = '0;
      res_d  = '0;
      mul_d  = 1'b0;
    end
    if ((state_q == ST_DIGIT) && xfer_c) begin
      prod_d = mul_q ? prod_q * RES_W'(opnd_q[idx_q]) : RES_W'(opnd_q[idx_q]);
      if (last_c) res_d = sum_q + prod_d;
    end
    if ((state_q == ST_OP) && xfer_c) begin
      if (ops_q[idx_q] == OP_MUL) begin
        mul_d = 1'b1;
      end else begin
        sum_d = sum_q + prod_q;
        mul_d = 1'b0;
      end
    end
  end

  // Evaluator registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sum_q  <= '0;
      prod_q <= '0;
      res_q  <= '0;
      mul_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      prod_q <= prod_d;
      res_q  <= res_d;
      mul_q  <= mul_d;
    end
  end

  assign result = res_q;
`else
  assign result = '0;
`endif

endmodule

// File: tb/tb_expr_tx.sv
// Scoreboard bench for expr_tx: stimulus pushes expected characters, a
// negedge monitor pops and compares on every transfer.
module tb_expr_tx;

  localparam int MT = 8;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          clr, start, out_ready;
  logic [3:0]    nterms;
  logic [4*MT-1:0] operands;
  logic [MT-2:0] ops;
  logic [7:0]    out_char;
  logic          out_valid, busy, done, err;
  logic [RW-1:0] result;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];
  bit   hold = 1'b0;
  logic [7:0] hold_char = 8'h00;

  expr_tx #(.MAX_TERMS(MT), .RES_W(RW)) dut (
    .clk(clk), .clr(clr), .start(start), .nterms(nterms), .operands(operands),
    .ops(ops), .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference value: split into '+'-separated product terms, then sum.
  function automatic longint model(input logic [3:0] n, input logic [31:0] opd,
                                   input logic [6:0] op);
    longint terms[$];
    longint s = 0;
    terms.push_back(longint'(opd[3:0]));
    for (int i = 1; i < int'(n); i++) begin
      longint d = longint'(opd[4*i +: 4]);
      if (op[i-1]) terms[terms.size()-1] = (terms[terms.size()-1] * d) % 65536;
      else         terms.push_back(d);
    end
    foreach (terms[k]) s += terms[k];
    return s % 65536;
  endfunction

  // Monitor: scoreboard pops, handshake stability, pulse counting.
  initial begin
    forever begin
      @(negedge clk);
      if (clr) begin
        hold = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (err)  err_cnt++;
        if (hold) begin
          chk("hold_valid", longint'(out_valid), 1);
          chk("hold_char", longint'(out_char), longint'(hold_char));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_char: got %0d expected none", out_char);
          end else begin
            chk("char", longint'(out_char), longint'(exp_q.pop_front()));
          end
        end
        hold = out_valid && !out_ready;
        hold_char = out_char;
      end
    end
  end

  task automatic send(input logic [3:0] n, input logic [31:0] opd, input logic [6:0] op,
                      input bit acc, input int st, input int sl, input bit rnd,
                      input int clr_c, input int bs_c);
    int c = 0;
    int stalls = 0;
    int d0, e0;
    bit got = 1'b0;
    longint exp_res;
    @(posedge clk); #1;
    nterms = n; operands = opd; ops = op; start = 1'b1;
    d0 = done_cnt; e0 = err_cnt;
    if (!acc) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      chk("rej_err", longint'(err), 1);
      chk("rej_valid", longint'(out_valid), 0);
      chk("rej_busy", longint'(busy), 0);
      @(negedge clk); #1;
      chk("rej_err_len", longint'(err), 0);
      chk("rej_busy2", longint'(busy), 0);
      chk("rej_no_done", done_cnt, d0);
      return;
    end
`ifdef EXPR_TX_EVAL_EN
    exp_res = model(n, opd, op);
`else
    exp_res = (model(n, opd, op) >= 0) ? 0 : 0;
`endif
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back(8'h30 + 8'(opd[4*i +: 4]));
      if (i < int'(n) - 1) exp_q.push_back(op[i] ? 8'h2A : 8'h2B);
    end
    while (!got && c < 400) begin
      @(posedge clk); #1;
      c++;
      if (c == 1) start = 1'b0;
      if (c == bs_c) begin
        start = 1'b1; nterms = ~n; operands = ~opd; ops = ~op;
      end
      if (c == bs_c + 1) start = 1'b0;
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(c >= st && c < st + sl);
      @(negedge clk); #1;
      if (c == 1) begin
        chk("valid_latency", longint'(out_valid), 1);
        chk("busy_on", longint'(busy), 1);
        chk("result_cleared", longint'(result), 0);
      end
      if (c == clr_c) begin
        clr = 1'b1;
        #1;
        chk("clr_valid", longint'(out_valid), 0);
        chk("clr_busy", longint'(busy), 0);
        chk("clr_done", longint'(done), 0);
        exp_q.delete();
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("no_done_after_clr", done_cnt, d0);
        chk("idle_after_clr", longint'(out_valid), 0);
        return;
      end
      if (out_valid && !out_ready) stalls++;
      if (done) got = 1'b1;
    end
    chk("done_seen", longint'(got), 1);
    chk("done_cycle", c, 2 * int'(n) + stalls);
    chk("busy_at_done", longint'(busy), 0);
    chk("valid_at_done", longint'(out_valid), 0);
    chk("result", longint'(result), exp_res);
    chk("queue_empty", exp_q.size(), 0);
    chk("no_err", err_cnt, e0);
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  rn;
    logic [31:0] ro;
    logic [6:0]  rop;
    clr = 1'b1; start = 1'b0; out_ready = 1'b1;
    nterms = '0; operands = '0; ops = '0;
    #12;
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_err", longint'(err), 0);
    chk("rst_char", longint'(out_char), 0);
    chk("rst_result", longint'(result), 0);
    @(negedge clk);
    clr = 1'b0;

    send(4'd3, 32'h0000_0321, 7'b0000010, 1, 0, 0, 0, -1, -1);   // 1+2*3
    send(4'd3, 32'h0000_0321, 7'b0000010, 1, 2, 3, 0, -1, -1);   // stall on '+'
    send(4'd1, 32'h0000_0009, 7'b0000000, 1, 0, 0, 0, -1, -1);   // single term
    send(4'd1, 32'h0000_000A, 7'b0000000, 0, 0, 0, 0, -1, -1);   // bad digit
    send(4'd0, 32'h0000_0001, 7'b0000000, 0, 0, 0, 0, -1, -1);   // zero terms
    send(4'd9, 32'h1111_1111, 7'b0000000, 0, 0, 0, 0, -1, -1);   // too many terms
    send(4'd2, 32'hFFFF_FF45, 7'b0000001, 1, 0, 0, 0, -1, -1);   // unused slots ignored
    send(4'd8, 32'h9876_5432, 7'b1111111, 1, 0, 0, 0, -1, -1);   // max terms, wraps
    send(4'd3, 32'h0000_0321, 7'b0000010, 1, 0, 0, 0, 3, -1);    // clr mid-stream
    send(4'd4, 32'h0000_8642, 7'b0000101, 1, 0, 0, 0, -1, -1);
    send(4'd3, 32'h0000_0574, 7'b0000001, 1, 0, 0, 0, -1, 3);    // start while busy
    send(4'd2, 32'h0000_0036, 7'b0000001, 1, 0, 0, 0, -1, -1);   // back-to-back

    for (int k = 0; k < 20; k++) begin
      rn = 4'($urandom_range(1, MT));
      for (int i = 0; i < MT; i++)
        ro[4*i +: 4] = (i < int'(rn)) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
      rop = 7'($urandom);
      send(rn, ro, rop, 1, 0, 0, 1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/expr_tx.md
Name: expr_tx

Overview:
- Character-stream transmitter: serializes a loaded arithmetic expression into ASCII characters, one per accepted transfer.
- Output is a well-formed stream of single digits separated by operators, `digit (op digit)*`, using only '0'-'9', '+' and '*'.
- Drives the expression-checking receiver and the test benches that feed it. Every completed stream drives that receiver into its accept state.

Parameters:
- MAX_TERMS, 8, maximum number of operand digits per expression (2..15).
- RES_W, 16, width of the evaluated result (only used with the optional feature).

Ports:
- clk  input  1  clock.
- clr  input  1  reset, asynchronous, active-high.
- start  input  1  load request; sampled only in IDLE.
- nterms  input  4  number of operand digits to send (1..MAX_TERMS).
- operands  input  4*MAX_TERMS  packed BCD digits; term i at bits [4i+3:4i], term 0 sent first.
- ops  input  MAX_TERMS-1  operator i sits between term i and term i+1; 0='+', 1='*'.
- out_char  output  8  ASCII character being offered.
- out_valid  output  1  out_char is valid.
- out_ready  input  1  consumer accepts out_char this cycle.
- busy  output  1  high from load until the done pulse.
- done  output  1  one-cycle pulse after the last character transfers.
- err  output  1  one-cycle pulse when a start is rejected.
- result  output  RES_W  evaluated expression value (optional feature).

Behaviour:
- Reset (clr high, asynchronous):
  - State goes to IDLE.
  - out_char=8'h00, out_valid=0, busy=0, done=0, err=0, result=0.
  - Applies immediately mid-stream; the partial stream is abandoned with no done pulse.
- States: IDLE, DIGIT, OP, FIN. Encoding is one-hot.
- IDLE:
  - On start=1, validate the request.
  - Reject if nterms==0, or nterms>MAX_TERMS, or any used operand (index < nterms) is >9.
  - On reject: err=1 on the next cycle; stay IDLE; no character is emitted.
  - On accept: latch nterms, operands and ops; idx=0; busy=1; go to DIGIT.
- Latency: out_valid rises the cycle after start is sampled.
- DIGIT:
  - out_valid=1, out_char = 8'h30 + operands[idx].
  - On out_valid && out_ready: if idx==nterms-1, go to FIN; else go to OP.
- OP:
  - out_valid=1, out_char = '+' (8'h2B) or '*' (8'h2A) from ops[idx].
  - On transfer: idx increments, go to DIGIT.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_char and out_valid hold stable.
  - out_valid never drops without a transfer, except on clr.
  - Ready being high with no valid has no effect.
  - With out_ready held high, one character transfers per cycle and the stream takes 2*nterms-1 cycles.
- FIN:
  - out_valid=0, done=1 for exactly one cycle, busy=0 in the same cycle.
  - Next state is IDLE, so a new start can be sampled in the cycle after FIN.
- start while busy is ignored; no err pulse.
- Latched inputs are immune to later changes on operands, ops or nterms.

Optional Feature:
- Macro: EXPR_TX_EVAL_EN.
- Defined:
  - result is the value of the transmitted expression, with '*' binding tighter than '+', computed modulo 2^RES_W.
  - Accumulators are `sum` and `prod`:
    - On the first digit of a term, prod=d; on a later digit after '*', prod=prod*d.
    - On a '+' transfer, sum=sum+prod.
  - At FIN, result = sum+prod, registered; it holds until the next accepted start or clr.
  - result is cleared to 0 on accepted start.
- Not defined: result is constant 0 and the accumulators are not synthesized.

Decomposition:
- Package expr_pkg:
  - ASCII constants CH_ZERO=8'h30, CH_PLUS=8'h2B, CH_STAR=8'h2A.
  - OP_ADD=0, OP_MUL=1.
  - One-hot state constants for IDLE, DIGIT, OP and FIN.
  - These are shared with the receiver's character classifier.
- Sub-module expr_char_enc (combinational):
  - Inputs: is_op, a 4-bit digit, a 1-bit op code.
  - Output: 8-bit ASCII character. It is the encoder counterpart of the receiver's classifier.
- FSM, index counter and evaluator stay in expr_tx.

Test Plan:
- 1+2*3: nterms=3, operands={3,2,1}, ops=2'b10, out_ready=1, start at cycle 0.
  - Chars "1","+","2","*","3" on cycles 1-5.
  - done on cycle 6.
  - result=7 with EXPR_TX_EVAL_EN.
- Backpressure on the same load: out_ready low for 3 cycles while "+" is offered.
  - out_char stays 8'h2B and out_valid stays 1 throughout.
  - Stream resumes unchanged; done is delayed by 3 cycles.
- Single term: nterms=1, operand 9.
  - One char 8'h39 on cycle 1, done on cycle 2, result=9.
- Rejected starts: operand 0 = 4'hA, then nterms=0.
  - err pulse each time, out_valid stays 0, busy stays 0.
- clr mid-stream, asserted between clock edges after the second character.
  - out_valid, busy and done go to 0 immediately.
  - No done pulse follows; the next start transmits the full new expression correctly.
- Start while busy, with different operands.
  - Ignored: the original stream completes unchanged and no err is raised.
  - A start in the cycle after done is accepted.
